// File: rtl/adder_cg_pkg.sv
// ----------------------------------------------------------------------------
// adder_cg_pkg
// Shared types for the clock-gated adder scheduler: FSM state encoding,
// default operand width, in-flight tag layout and a saturating counter helper.
// No ports (package).
// ----------------------------------------------------------------------------
package adder_cg_pkg;

   localparam int DW_DEF = 16;
   // Tag id is sized for the largest supported requester count (8).
   localparam int ID_W   = 3;

   typedef enum logic [1:0] {
      ST_GATED  = 2'd0,
      ST_WAKE   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_IDLE   = 2'd3
   } state_t;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
   endfunction

endpackage

// File: rtl/adder_cg_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Priority starts at the pointer; after a grant to i the
// pointer moves to (i+1) mod N, otherwise it holds.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   req [N]      request vector
//   en           grants allowed this cycle
//   grant [N]    one-hot grant (combinational), zero when en=0 or no request
//   grant_id     index of the granted requester (meaningful when |grant)
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_id
);

   logic [PW-1:0] ptr_r;
   logic          hi_hit_s;
   logic [PW-1:0] hi_id_s;
   logic          lo_hit_s;
   logic [PW-1:0] lo_id_s;

   // Lowest requester at/above the pointer wins; else lowest requester overall.
   always_comb begin
      hi_hit_s = 1'b0;
      hi_id_s  = '0;
      lo_hit_s = 1'b0;
      lo_id_s  = '0;
      // Scan downward so the lowest matching index is the one left standing.
      for (int i = N - 1; i >= 0; i--) begin
         hi_hit_s = hi_hit_s | (req[i] & (PW'(i) >= ptr_r));
         hi_id_s  = (req[i] && (PW'(i) >= ptr_r)) ? PW'(i) : hi_id_s;
         lo_hit_s = lo_hit_s | req[i];
         lo_id_s  = req[i] ? PW'(i) : lo_id_s;
      end
      grant_id = hi_hit_s ? hi_id_s : lo_id_s;
      grant    = (en && lo_hit_s) ? (N'(1'b1) << grant_id) : '0;
   end

   // Pointer advances past the granted requester.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r <= '0;
      end else if (|grant) begin
         ptr_r <= (grant_id == PW'(N - 1)) ? '0 : (grant_id + PW'(1));
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/adder_cg_scheduler.sv
// ----------------------------------------------------------------------------
// adder_cg_scheduler
// Shares one clock-gated adder between N_REQ requesters. Owns the adder clock
// enable: wakes it on demand, lets it settle for WAKE_CYC cycles before the
// first issue, and gates it after IDLE_CYC quiet cycles with nothing in flight.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     per-requester handshake (ready is one-hot, comb.)
//   req_a, req_b, req_cin   packed operands, requester i at [i*DW +: DW]
//   add_a, add_b, add_cin   registered operands to the adder (hold when idle)
//   add_sum, add_cout       adder result, valid ADD_LAT cycles after operands
//   cg_en                   registered adder clock enable
//   rsp_valid/id/sum/cout   one-cycle result pulse tagged with requester id
//   gated_cnt               saturating count of cycles with cg_en=0
// ----------------------------------------------------------------------------
module adder_cg_scheduler
   import adder_cg_pkg::*;
#(
   parameter  int N_REQ    = 2,
   parameter  int DW       = DW_DEF,
   parameter  int ADD_LAT  = 1,
   parameter  int WAKE_CYC = 2,
   parameter  int IDLE_CYC = 8,
   localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*DW-1:0] req_a,
   input  logic [N_REQ*DW-1:0] req_b,
   input  logic [N_REQ-1:0]    req_cin,
   output logic [N_REQ-1:0]    req_ready,
   output logic [DW-1:0]       add_a,
   output logic [DW-1:0]       add_b,
   output logic                add_cin,
   input  logic [DW-1:0]       add_sum,
   input  logic                add_cout,
   output logic                cg_en,
   output logic                rsp_valid,
   output logic [IW-1:0]       rsp_id,
   output logic [DW-1:0]       rsp_sum,
   output logic                rsp_cout,
   output logic [31:0]         gated_cnt
);

   localparam int          WCW       = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
   localparam int          ICW       = $clog2(IDLE_CYC + 1);
   localparam logic [31:0] WAKE_LAST = 32'((WAKE_CYC > 0) ? (WAKE_CYC - 1) : 0);
   localparam logic [31:0] IDLE_LAST = 32'(IDLE_CYC - 1);

   state_t           state_r, state_nxt_s;
   logic [WCW-1:0]   wake_cnt_r, wake_cnt_nxt_s;
   logic [ICW-1:0]   idle_cnt_r, idle_cnt_nxt_s;
   logic             cg_en_r;
   logic [N_REQ-1:0] grant_s;
   logic [IW-1:0]    grant_id_s;
   logic             arb_en_s, fire_s, any_valid_s, in_flight_s;
   logic [DW-1:0]    sel_a_s, sel_b_s;
   logic             sel_cin_s;
   logic [DW-1:0]    add_a_r, add_b_r;
   logic             add_cin_r;
   tag_t             tag_pipe_r [ADD_LAT+1];
   tag_t             tag_last_s;
   logic             rsp_valid_r, rsp_cout_r;
   logic [IW-1:0]    rsp_id_r;
   logic [DW-1:0]    rsp_sum_r;
   logic [31:0]      gated_cnt_r;

   assign arb_en_s    = (state_r == ST_ACTIVE) || (state_r == ST_IDLE);
   assign any_valid_s = |req_valid;
   // A grant is only ever raised on a valid request, so a grant is a transfer.
   assign fire_s      = |grant_s;
   assign tag_last_s  = tag_pipe_r[ADD_LAT];

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .req      (req_valid),
      .en       (arb_en_s),
      .grant    (grant_s),
      .grant_id (grant_id_s)
   );

   // Operand mux from the one-hot grant, plus the in-flight summary.
   always_comb begin
      sel_a_s     = '0;
      sel_b_s     = '0;
      sel_cin_s   = 1'b0;
      in_flight_s = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_a_s   = grant_s[i] ? req_a[i*DW +: DW] : sel_a_s;
         sel_b_s   = grant_s[i] ? req_b[i*DW +: DW] : sel_b_s;
         sel_cin_s = grant_s[i] ? req_cin[i] : sel_cin_s;
      end
      for (int k = 0; k <= ADD_LAT; k++) begin
         in_flight_s = in_flight_s | tag_pipe_r[k].valid;
      end
   end

   // Power FSM next state with wake and idle hold-off counters.
   always_comb begin
      state_nxt_s    = state_r;
      wake_cnt_nxt_s = wake_cnt_r;
      idle_cnt_nxt_s = idle_cnt_r;
      case (state_r)
         ST_GATED: begin
            wake_cnt_nxt_s = '0;
            idle_cnt_nxt_s = '0;
            if (any_valid_s) begin
               state_nxt_s = (WAKE_CYC == 0) ? ST_ACTIVE : ST_WAKE;
            end else begin
               state_nxt_s = ST_GATED;
            end
         end
         ST_WAKE: begin
            if (32'(wake_cnt_r) >= WAKE_LAST) begin
               state_nxt_s    = ST_ACTIVE;
               wake_cnt_nxt_s = '0;
            end else begin
               wake_cnt_nxt_s = wake_cnt_r + WCW'(1);
            end
         end
         ST_ACTIVE: begin
            idle_cnt_nxt_s = '0;
            if (any_valid_s) begin
               state_nxt_s = ST_ACTIVE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_IDLE: begin
            // Only fully quiet cycles count; the clock never stops under a tag.
            if (fire_s) begin
               state_nxt_s    = ST_ACTIVE;
               idle_cnt_nxt_s = '0;
            end else if (any_valid_s || in_flight_s) begin
               idle_cnt_nxt_s = '0;
            end else if (32'(idle_cnt_r) >= IDLE_LAST) begin
               state_nxt_s    = ST_GATED;
               idle_cnt_nxt_s = '0;
            end else begin
               idle_cnt_nxt_s = idle_cnt_r + ICW'(1);
            end
         end
         default: begin
            state_nxt_s    = ST_GATED;
            wake_cnt_nxt_s = '0;
            idle_cnt_nxt_s = '0;
         end
      endcase
   end

   // FSM state, counters and the registered clock enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_GATED;
         wake_cnt_r <= '0;
         idle_cnt_r <= '0;
         cg_en_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wake_cnt_r <= wake_cnt_nxt_s;
         idle_cnt_r <= idle_cnt_nxt_s;
         cg_en_r    <= (state_nxt_s != ST_GATED);
      end
   end

   // Operand registers load only on a transfer so the adder inputs stay still.
   always_ff @(posedge clk) begin
      if (reset) begin
         add_a_r   <= '0;
         add_b_r   <= '0;
         add_cin_r <= 1'b0;
      end else if (fire_s) begin
         add_a_r   <= sel_a_s;
         add_b_r   <= sel_b_s;
         add_cin_r <= sel_cin_s;
      end else begin
         add_a_r   <= add_a_r;
         add_b_r   <= add_b_r;
         add_cin_r <= add_cin_r;
      end
   end

   // Tag pipe: stage 0 aligns with the operand registers, last stage with add_sum.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k <= ADD_LAT; k++) begin
            tag_pipe_r[k] <= '0;
         end
      end else begin
         tag_pipe_r[0].valid <= fire_s;
         tag_pipe_r[0].id    <= ID_W'(grant_id_s);
         for (int k = 1; k <= ADD_LAT; k++) begin
            tag_pipe_r[k] <= tag_pipe_r[k-1];
         end
      end
   end

   // Response capture; data holds between pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= '0;
         rsp_sum_r   <= '0;
         rsp_cout_r  <= 1'b0;
      end else if (tag_last_s.valid) begin
         rsp_valid_r <= 1'b1;
         rsp_id_r    <= IW'(tag_last_s.id);
         rsp_sum_r   <= add_sum;
         rsp_cout_r  <= add_cout;
      end else begin
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= rsp_id_r;
         rsp_sum_r   <= rsp_sum_r;
         rsp_cout_r  <= rsp_cout_r;
      end
   end

   // Gated-cycle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         gated_cnt_r <= 32'd0;
      end else if (!cg_en_r) begin
         gated_cnt_r <= sat_inc32(gated_cnt_r);
      end else begin
         gated_cnt_r <= gated_cnt_r;
      end
   end

   assign req_ready = grant_s;
   assign add_a     = add_a_r;
   assign add_b     = add_b_r;
   assign add_cin   = add_cin_r;
   assign cg_en     = cg_en_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_id    = rsp_id_r;
   assign rsp_sum   = rsp_sum_r;
   assign rsp_cout  = rsp_cout_r;
   assign gated_cnt = gated_cnt_r;

endmodule

// File: tb/tb_adder_cg_scheduler.sv
// ----------------------------------------------------------------------------
// tb_adder_cg_scheduler
// Directed bench for adder_cg_scheduler with default parameters (2 requesters,
// 16-bit, ADD_LAT=1, WAKE_CYC=2, IDLE_CYC=8). A one-cycle registered adder
// stands in for the gated adder. Inputs change 1 time unit after the rising
// edge; outputs are sampled there as well.
// ----------------------------------------------------------------------------
module tb_adder_cg_scheduler;

   localparam int N  = 2;
   localparam int DW = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_a;
   logic [N*DW-1:0]   req_b;
   logic [N-1:0]      req_cin;
   logic [N-1:0]      req_ready;
   logic [DW-1:0]     add_a, add_b;
   logic              add_cin;
   logic [DW-1:0]     add_sum;
   logic              add_cout;
   logic              cg_en;
   logic              rsp_valid;
   logic [0:0]        rsp_id;
   logic [DW-1:0]     rsp_sum;
   logic              rsp_cout;
   logic [31:0]       gated_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   adder_cg_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_ready (req_ready),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .cg_en     (cg_en),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .gated_cnt (gated_cnt)
   );

   // Stand-in adder with one cycle of latency.
   always @(posedge clk) begin
      {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
      repeat (3) step();
      n_checks++;
      if ({cg_en, req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b, add_cin} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: cg_en=%0b ready=%b rsp_valid=%0b add_a=%h add_b=%h, all want 0",
                  cg_en, req_ready, rsp_valid, add_a, add_b);
      end
      n_checks++;
      if (gated_cnt !== 32'd0) begin
         n_fail++; $display("FAIL reset_gated_cnt: got %0d want 0", gated_cnt);
      end
      reset = 1'b0;
      repeat (100) step();
      n_checks++;
      if (gated_cnt !== 32'd100) begin
         n_fail++; $display("FAIL idle100_gated_cnt: got %0d want 100", gated_cnt);
      end
      n_checks++;
      if (cg_en !== 1'b0) begin
         n_fail++; $display("FAIL idle100_cg_en: got %0b want 0", cg_en);
      end
      n_checks++;
      if ({add_a, add_b, add_cin, rsp_valid} !== '0) begin
         n_fail++; $display("FAIL idle100_add: add_a=%h add_b=%h cin=%0b rsp_valid=%0b want 0",
                            add_a, add_b, add_cin, rsp_valid);
      end
   endtask

   task automatic test_wake();
      req_valid = 2'b01; req_a[15:0] = 16'hA5A5; req_b[15:0] = 16'h5A5A; req_cin = 2'b00;
      #1;
      n_checks++;
      if (req_ready !== 2'b00) begin
         n_fail++; $display("FAIL gated_ready: got %b want 00", req_ready);
      end
      step();
      n_checks++;
      if (cg_en !== 1'b1) begin
         n_fail++; $display("FAIL wake_cg_en: got %0b want 1", cg_en);
      end
      n_checks++;
      if (req_ready !== 2'b00) begin
         n_fail++; $display("FAIL wake_ready0: got %b want 00", req_ready);
      end
      n_checks++;
      if (gated_cnt !== 32'd101) begin
         n_fail++; $display("FAIL wake_gated_cnt: got %0d want 101", gated_cnt);
      end
      step();
      n_checks++;
      if (req_ready !== 2'b00) begin
         n_fail++; $display("FAIL wake_ready1: got %b want 00", req_ready);
      end
      step();
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL active_ready: got %b want 01", req_ready);
      end
      step();
      req_valid = 2'b00;
      n_checks++;
      if ({add_a, add_b, add_cin} !== {16'hA5A5, 16'h5A5A, 1'b0}) begin
         n_fail++; $display("FAIL issue_operands: got %h/%h/%0b want a5a5/5a5a/0", add_a, add_b, add_cin);
      end
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL wake_rsp_early: got %0b want 0", rsp_valid);
      end
      step();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 1'b0, 16'hFFFF, 1'b0}) begin
         n_fail++; $display("FAIL wake_rsp: got v=%0b id=%0d sum=%h c=%0b want v=1 id=0 sum=ffff c=0",
                            rsp_valid, rsp_id, rsp_sum, rsp_cout);
      end
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL wake_rsp_pulse: got %0b want 0", rsp_valid);
      end
   endtask

   task automatic test_idle_gate();
      // Response cycle was 2 steps ago; cg_en must stay high until 8 cycles after it.
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if (cg_en !== 1'b1) begin
            n_fail++; $display("FAIL idle_hold_cg_en[%0d]: got %0b want 1", i, cg_en);
         end
      end
      step();
      n_checks++;
      if (cg_en !== 1'b0) begin
         n_fail++; $display("FAIL idle_gate_cg_en: got %0b want 0", cg_en);
      end
      n_checks++;
      if ({add_a, add_b} !== {16'hA5A5, 16'h5A5A}) begin
         n_fail++; $display("FAIL idle_add_hold: got %h/%h want a5a5/5a5a", add_a, add_b);
      end
      n_checks++;
      if (gated_cnt !== 32'd101) begin
         n_fail++; $display("FAIL idle_gated_cnt_frozen: got %0d want 101", gated_cnt);
      end
      step();
      n_checks++;
      if (gated_cnt !== 32'd102) begin
         n_fail++; $display("FAIL idle_gated_cnt_resume: got %0d want 102", gated_cnt);
      end
   endtask

   task automatic test_two_req();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      req_valid = 2'b11;
      req_a = {16'hFFFF, 16'h1707}; req_b = {16'h0001, 16'h2345}; req_cin = 2'b00;
      repeat (3) step();
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL two_grant0: got %b want 01", req_ready);
      end
      step();
      n_checks++;
      if ({add_a, add_b} !== {16'h1707, 16'h2345}) begin
         n_fail++; $display("FAIL two_ops0: got %h/%h want 1707/2345", add_a, add_b);
      end
      req_valid = 2'b10;
      #1;
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_fail++; $display("FAIL two_grant1: got %b want 10", req_ready);
      end
      step();
      req_valid = 2'b00;
      n_checks++;
      if ({add_a, add_b} !== {16'hFFFF, 16'h0001}) begin
         n_fail++; $display("FAIL two_ops1: got %h/%h want ffff/0001", add_a, add_b);
      end
      step();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 1'b0, 16'h3A4C, 1'b0}) begin
         n_fail++; $display("FAIL two_rsp0: got v=%0b id=%0d sum=%h c=%0b want v=1 id=0 sum=3a4c c=0",
                            rsp_valid, rsp_id, rsp_sum, rsp_cout);
      end
      step();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 1'b1, 16'h0000, 1'b1}) begin
         n_fail++; $display("FAIL two_rsp1: got v=%0b id=%0d sum=%h c=%0b want v=1 id=1 sum=0000 c=1",
                            rsp_valid, rsp_id, rsp_sum, rsp_cout);
      end
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL two_rsp_end: got %0b want 0", rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [16:0] exp_res [10];
      logic [15:0] a0, b0, a1, b1;
      logic        id_e;
      for (int c = 0; c < 12; c++) begin
         if (c < 10) begin
            a0 = 16'h1111 * 16'(c); b0 = 16'h0101;
            a1 = 16'hF000 + 16'(c); b1 = 16'h1000;
            req_valid = 2'b11; req_a = {a1, a0}; req_b = {b1, b0}; req_cin = 2'b10;
            id_e = c[0];
            exp_res[c] = id_e ? ({1'b0, a1} + {1'b0, b1} + 17'd1) : ({1'b0, a0} + {1'b0, b0});
            #1;
            n_checks++;
            if (req_ready !== (id_e ? 2'b10 : 2'b01)) begin
               n_fail++; $display("FAIL b2b_grant[%0d]: got %b want %b", c, req_ready, id_e ? 2'b10 : 2'b01);
            end
         end else begin
            req_valid = 2'b00;
         end
         step();
         if (c >= 2) begin
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 1'((c - 2) % 2), exp_res[c-2]}) begin
               n_fail++; $display("FAIL b2b_rsp[%0d]: got v=%0b id=%0d c=%0b sum=%h want v=1 id=%0d c/sum=%h",
                                  c - 2, rsp_valid, rsp_id, rsp_cout, rsp_sum, (c - 2) % 2, exp_res[c-2]);
            end
         end
      end
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_rsp_end: got %0b want 0", rsp_valid);
      end
   endtask

   task automatic test_reset_midop();
      req_valid = 2'b01; req_a = {16'h0000, 16'h1234}; req_b = {16'h0000, 16'h1111}; req_cin = 2'b00;
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL midop_grant: got %b want 01", req_ready);
      end
      step();
      req_valid = 2'b00;
      reset = 1'b1;
      n_checks++;
      if (add_a !== 16'h1234) begin
         n_fail++; $display("FAIL midop_issue: got %h want 1234", add_a);
      end
      step();
      n_checks++;
      if ({cg_en, req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b, add_cin, gated_cnt} !== '0) begin
         n_fail++; $display("FAIL midop_reset_outputs: cg_en=%0b rsp_valid=%0b add_a=%h gated_cnt=%0d want 0",
                            cg_en, rsp_valid, add_a, gated_cnt);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if ({rsp_valid, cg_en, req_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL midop_quiet[%0d]: rsp_valid=%0b cg_en=%0b ready=%b want 0",
                               i, rsp_valid, cg_en, req_ready);
         end
      end
      n_checks++;
      if (gated_cnt !== 32'd4) begin
         n_fail++; $display("FAIL midop_gated_cnt: got %0d want 4", gated_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_wake();
      test_idle_gate();
      test_two_req();
      test_back_to_back();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
